// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over
// the shared open-drain PS2_CLK / PS2_DATA pair:
//   1. inhibit: hold PS2_CLK low, then pull PS2_DATA low (start bit),
//   2. release PS2_CLK and let the device generate the clock,
//   3. present data bits (LSB first), odd parity and stop, one per device
//      falling edge,
//   4. sample the device ACK on the following falling edge,
//   5. wait for the bus to go idle and report done (or err on NACK/timeout).
//
// Ports:
//   clk       in     system clock
//   rst       in     asynchronous, active-high reset
//   tx_data   in  8  command byte, captured when tx_valid & tx_ready
//   tx_valid  in     request to send tx_data
//   tx_ready  out    high only while idle and not reporting a result
//   busy      out    high whenever a transmission owns the bus
//   done      out    one-cycle pulse: byte sent and ACK received
//   err       out    one-cycle pulse: NACK or timeout
//   PS2_CLK   inout  open drain, driven low or released, never driven high
//   PS2_DATA  inout  open drain, driven low or released, never driven high
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    inout  logic       PS2_CLK,
    inout  logic       PS2_DATA
);

    // One counter serves both the inhibit interval and the timeout, so it is
    // sized for whichever of the two is larger.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                               : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // The clock frequency only documents the cycle counts above; reject
    // settings that would make the counters meaningless.
    if (CLK_FREQ_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: CLK_FREQ_HZ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [9:0]       shift_q,    shift_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;
    logic             clk_low_q,  clk_low_d;
    logic             data_low_q, data_low_d;

    logic             clk_meta_q,  clk_meta_d;
    logic             clk_sync_q,  clk_sync_d;
    logic             clk_prev_q,  clk_prev_d;
    logic             data_meta_q, data_meta_d;
    logic             data_sync_q, data_sync_d;

    logic             clk_fall;
    logic             accept;
    logic             timeout_hit;

    // Open-drain pads: a registered enable either pulls the line low or lets
    // the external pull-up take it high. Reset clears the enables
    // asynchronously, so the bus is freed the moment rst rises.
    assign PS2_CLK  = clk_low_q  ? 1'b0 : 1'bz;
    assign PS2_DATA = data_low_q ? 1'b0 : 1'bz;

    assign done = done_q;
    assign err  = err_q;

    // Two-stage synchronizers for the bus lines plus one extra stage on the
    // clock so a device falling edge can be detected on synchronized values.
    always_comb begin
        clk_meta_d  = PS2_CLK;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = PS2_DATA;
        data_sync_d = data_meta_q;
    end

    assign clk_fall    = clk_prev_q & ~clk_sync_q;
    assign accept      = tx_valid & tx_ready;
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    // State register. Synchronizer stages reset to 1 (idle bus level) so no
    // spurious falling edge is seen when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_low_q   <= 1'b0;
            data_low_q  <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_low_q   <= clk_low_d;
            data_low_q  <= data_low_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    // Next-state logic. The shared counter times the inhibit phase, then is
    // cleared and reused as the timeout from CLK release until the bus is
    // idle again. Timeout takes priority over any edge seen in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Frame, LSB first: data, odd parity, stop.
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SEND: begin
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_fall) begin
                        // shift_q[0] goes out on the line this edge; the
                        // tenth edge presents the stop bit.
                        shift_d   = {1'b0, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = WAIT_ACK;
                        end
                    end
                end
            end

            WAIT_ACK: begin
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_fall) begin
                        if (!data_sync_q) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end

            WAIT_IDLE: begin
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_sync_q && data_sync_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. Line drives are computed from the next state so the
    // registered pad enables change in the same cycle the state does.
    // tx_ready is held off during the done/err cycle so a new request can
    // never be accepted while a result is being reported.
    always_comb begin
        tx_ready   = (state_q == IDLE) && !done_q && !err_q;
        busy       = (state_q != IDLE);
        clk_low_d  = (state_d == INHIBIT);
        data_low_d = 1'b0;

        case (state_d)
            INHIBIT: begin
                // Start bit goes out during the final inhibit cycle.
                data_low_d = (cnt_d == INHIBIT_LAST);
            end
            SEND: begin
                if (state_q != SEND) begin
                    data_low_d = 1'b1;
                end else if (clk_fall) begin
                    data_low_d = ~shift_q[0];
                end else begin
                    data_low_d = data_low_q;
                end
            end
            default: begin
                data_low_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-
// drain bus. Each accepted byte pushes its expected 10-bit frame
// {stop, parity, data} onto a scoreboard; the device model pops it when it
// has clocked a frame out of the host and compares the bits it sampled.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 2000;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    wire        ps2_clk;
    wire        ps2_data;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    int         compared   = 0;
    int         mismatched = 0;
    int         done_cnt   = 0;
    int         err_cnt    = 0;

    logic [9:0] exp_q[$];

    // Bus lines idle high through pull-ups; the device model can only pull
    // them low, just like the host.
    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .CLK_FREQ_HZ   (100_000_000),
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .PS2_CLK (ps2_clk),
        .PS2_DATA(ps2_data)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Count every done/err cycle so stray pulses can be spotted later.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    // Single comparison point: counts, asserts, reports.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one request on a falling edge and push the frame the device
    // should see. With hold set, tx_valid stays high afterwards.
    task automatic applyStimulus(input logic [7:0] b, input logic parity, input bit hold);
        @(negedge clk);
        checkOutput("ready_before_send", {15'd0, tx_ready}, 16'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, parity, b});
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        checkOutput("busy_after_accept", {15'd0, busy}, 16'd1);
        checkOutput("ready_after_accept", {15'd0, tx_ready}, 16'd0);
    endtask

    // Device side of the request: measure how long CLK is held low and
    // what DATA shows when CLK is released. Returns on the release cycle.
    task automatic waitRequest(output int low_cycles, output logic start_bit);
        int n;
        n = 0;
        low_cycles = 0;
        start_bit  = 1'b1;
        while (ps2_clk !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("request_seen", {15'd0, (n < 50)}, 16'd1);
        while (ps2_clk === 1'b0 && low_cycles < 1000) begin
            low_cycles++;
            @(negedge clk);
        end
        start_bit = ps2_data;
    endtask

    // Device generates n clock pulses (20 low / 20 high) and samples DATA
    // just before each rising edge.
    task automatic clockBits(input int n, output logic [9:0] bits);
        bits = '0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            bits[i] = ps2_data;
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
        end
    endtask

    // Bounded wait for done/err; checks tx_ready is low during the pulse and
    // back high, with the pulse gone, one cycle later.
    task automatic waitPulse(output logic got_done, output logic got_err);
        int n;
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pulse_seen", {15'd0, (n < 300)}, 16'd1);
        got_done = done;
        got_err  = err;
        checkOutput("ready_during_pulse", {15'd0, tx_ready}, 16'd0);
        @(negedge clk);
        checkOutput("pulse_one_cycle", {14'd0, done, err}, 16'd0);
        checkOutput("ready_after_pulse", {15'd0, tx_ready}, 16'd1);
    endtask

    // Full device transaction: request, 10 data/parity/stop clocks compared
    // against the scoreboard, then an 11th clock with ACK or NACK.
    task automatic runFrame(input bit ack);
        int         low;
        logic       start;
        logic [9:0] bits;
        logic [9:0] expect_bits;
        logic       got_done;
        logic       got_err;

        waitRequest(low, start);
        checkOutput("clk_low_cycles", 16'(low), 16'(INHIBIT));
        checkOutput("start_bit", {15'd0, start}, 16'd0);
        clockBits(10, bits);
        checkOutput("sb_nonempty", {15'd0, (exp_q.size() > 0)}, 16'd1);
        expect_bits = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        checkOutput("frame_bits", {6'd0, bits}, {6'd0, expect_bits});

        if (ack) begin
            dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
            waitPulse(got_done, got_err);
        end else begin
            dev_clk_low = 1'b1;
            waitPulse(got_done, got_err);
            repeat (15) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
        end
        checkOutput("done_result", {15'd0, got_done}, {15'd0, ack});
        checkOutput("err_result", {15'd0, got_err}, {15'd0, !ack});
    endtask

    // Directed sequence: reset, ACKed sends, NACK, timeout, held request,
    // reset mid-frame.
    initial begin
        int         low;
        int         n;
        int         d0;
        int         e0;
        logic       start;
        logic [9:0] bits;

        $display("[TB] reset checks");
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        checkOutput("rst_done", {15'd0, done}, 16'd0);
        checkOutput("rst_err", {15'd0, err}, 16'd0);
        checkOutput("rst_ps2_clk", {15'd0, ps2_clk}, 16'd1);
        checkOutput("rst_ps2_data", {15'd0, ps2_data}, 16'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] send 0xED with ACK");
        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(8'hED, 1'b1, 1'b0);
        runFrame(1'b1);
        checkOutput("ed_done_count", 16'(done_cnt - d0), 16'd1);
        checkOutput("ed_err_count", 16'(err_cnt - e0), 16'd0);

        $display("[TB] send 0xF4, 0x02, 0xFF with ACK");
        applyStimulus(8'hF4, 1'b0, 1'b0);
        runFrame(1'b1);
        applyStimulus(8'h02, 1'b0, 1'b0);
        runFrame(1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        runFrame(1'b1);

        $display("[TB] NACK from device");
        d0 = done_cnt;
        applyStimulus(8'hF4, 1'b0, 1'b0);
        runFrame(1'b0);
        checkOutput("nack_no_done", 16'(done_cnt - d0), 16'd0);

        $display("[TB] device never clocks");
        applyStimulus(8'h55, 1'b1, 1'b0);
        waitRequest(low, start);
        checkOutput("to_clk_low_cycles", 16'(low), 16'(INHIBIT));
        void'(exp_q.pop_front());
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 16'(n), 16'(TIMEOUT));
        checkOutput("timeout_ps2_clk", {15'd0, ps2_clk}, 16'd1);
        checkOutput("timeout_ps2_data", {15'd0, ps2_data}, 16'd1);
        checkOutput("timeout_ready_low", {15'd0, tx_ready}, 16'd0);
        @(negedge clk);
        checkOutput("timeout_ready_after", {15'd0, tx_ready}, 16'd1);
        repeat (5) @(negedge clk);

        $display("[TB] tx_valid held with a different byte during a frame");
        applyStimulus(8'hED, 1'b1, 1'b1);
        tx_data = 8'h12;
        exp_q.push_back({1'b1, 1'b1, 8'h12});
        runFrame(1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("held_accepted_after_done", {15'd0, busy}, 16'd1);
        runFrame(1'b1);
        checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] reset during bit 4");
        applyStimulus(8'hED, 1'b1, 1'b0);
        waitRequest(low, start);
        clockBits(5, bits);
        checkOutput("abort_bits_so_far", {11'd0, bits[4:0]}, {11'd0, 5'b01101});
        checkOutput("abort_data_driven", {15'd0, ps2_data}, 16'd0);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        #1;
        checkOutput("abort_ps2_data", {15'd0, ps2_data}, 16'd1);
        checkOutput("abort_ps2_clk", {15'd0, ps2_clk}, 16'd1);
        checkOutput("abort_busy", {15'd0, busy}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 16'(done_cnt - d0), 16'd0);
        checkOutput("abort_no_err", 16'(err_cnt - e0), 16'd0);
        applyStimulus(8'hF4, 1'b0, 1'b0);
        runFrame(1'b1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
